inv_mixed_column_block: RTL and testbench

Sequential GF(2^8) column-mixing engine for the AES datapath. It is the decrypt-side counterpart of the combinational mixed_column_block: by default it applies InvMixColumns (matrix 0E 0B 0D 09) to a 4x4 byte state. A per-block mode bit selects the forward MixColumns matrix (02 03 01 01) instead, for round-trip checking. The block computes one column per clock behind valid/ready handshakes on both sides, and sits between the inverse ShiftRows/SubBytes stages and AddRoundKey.

---
 rtl/inv_mixed_column_block.sv | 110 +++++++++++
 tb/tb_inv_mixed_column_block.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inv_mixed_column_block.sv
// inv_mixed_column_block: one-column-per-cycle AES (Inv)MixColumns engine with valid/ready handshakes
module inv_mixed_column_block (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_fwd_i,
    input  logic [3:0][3:0][7:0]  in_state_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0][3:0][7:0]  out_state_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           col_q, col_d;
    logic                 mode_q, mode_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic [3:0][3:0][7:0] buf_q, buf_d;
    logic [3:0][3:0][7:0] out_q, out_d;
    logic [3:0][7:0]      col_res;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // m is a 4-bit constant, so the product is a XOR of the ×1/×2/×4/×8 chain
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return ({8{m[0]}} & a) ^ ({8{m[1]}} & a2) ^ ({8{m[2]}} & a4) ^ ({8{m[3]}} & a8);
    endfunction

    // Both matrices are circulant: row r is row 0 rotated right by r, so only the offset k-r matters
    function automatic logic [3:0] coef(input logic fwd, input logic [1:0] i);
        return fwd ? (i == 2'd0 ? 4'h2 : i == 2'd1 ? 4'h3 : 4'h1)
                   : (i == 2'd0 ? 4'he : i == 2'd1 ? 4'hb : i == 2'd2 ? 4'hd : 4'h9);
    endfunction

    // Column col of the captured state multiplied by the captured matrix
    always_comb begin
        col_res = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                col_res[r] = col_res[r] ^ gmul(buf_q[k][col_q], coef(mode_q, 2'(k - r)));
    end

    // FSM next-state: accept in IDLE, one column per CALC cycle, hold result in DONE until taken
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        mode_d      = mode_q;
        buf_d       = buf_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                buf_d   = in_state_i;
                mode_d  = in_fwd_i;
                col_d   = 2'd0;
                state_d = CALC;
            end
            CALC: begin
                for (int r = 0; r < 4; r++)
                    out_d[r][col_q] = col_res[r];
                col_d = (col_q == 2'd3) ? col_q : col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: if (out_ready_i) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous active-low reset that aborts any block in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            mode_q      <= 1'b0;
            buf_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            mode_q      <= mode_d;
            buf_q       <= buf_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign out_state_o = out_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_inv_mixed_column_block.sv
// tb_inv_mixed_column_block: vector table, backpressure, reset abort and random round-trip checks
module tb_inv_mixed_column_block;
    typedef logic [3:0][3:0][7:0] st_t;
    typedef struct {
        st_t  si;
        logic fw;
        st_t  se;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_fwd, out_valid, out_ready, busy;
    st_t  in_state, out_state;
    int   vectors = 0;
    int   miscompares = 0;
    st_t  exp_q[$];
    vec_t vt[3];

    always #5 clk = ~clk;

    inv_mixed_column_block dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_fwd_i(in_fwd), .in_state_i(in_state), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_state_o(out_state), .busy_o(busy)
    );

    // Rows given in reading order: byte c of each row word is column c
    function automatic st_t mk(input logic [31:0] r0, r1, r2, r3);
        st_t s;
        logic [3:0][31:0] rows;
        rows = {r3, r2, r1, r0};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = rows[r][31 - 8 * c -: 8];
        return s;
    endfunction

    // Reference GF(2^8) multiply by shift-and-add over the bits of b
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic st_t model(input st_t s, input logic f);
        logic [7:0] fm[4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                                 '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
        logic [7:0] im[4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                 '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        st_t o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++)
                    o[r][c] = o[r][c] ^ gm(f ? fm[r][k] : im[r][k], s[k][c]);
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One full block: accept, check latency, compare against scoreboard, check the 1-cycle valid pulse
    task automatic do_block(input st_t s, input logic f, input st_t exp, output st_t got);
        int n;
        exp_q.push_back(exp);
        in_state  = s;
        in_fwd    = f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("in_ready_before_accept", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_fwd   = ~f;
        wait_valid(n);
        chk("latency", 128'(n), 128'd4);
        got = out_state;
        chk("out_state", got, exp_q.pop_front());
        tick();
        chk("valid_pulse_end", 128'(out_valid), 128'd0);
        chk("in_ready_after_handshake", 128'(in_ready), 128'd1);
    endtask

    initial begin
        st_t got, back, s;
        int  n;
        vt[0] = '{mk(32'h4740A34C, 32'h37D4709F, 32'h94E43A42, 32'hEDA5A6BC), 1'b0,
                  mk(32'h87F24D97, 32'h6E4C90EC, 32'h46E74AC3, 32'hA68CD895)};
        vt[1] = '{mk(32'h87F24D97, 32'h6E4C90EC, 32'h46E74AC3, 32'hA68CD895), 1'b1,
                  mk(32'h4740A34C, 32'h37D4709F, 32'h94E43A42, 32'hEDA5A6BC)};
        vt[2] = '{mk(32'h8E9F01C6, 32'h4DDC01C6, 32'hA15801C6, 32'hBC9D01C6), 1'b0,
                  mk(32'hDBF201C6, 32'h130A01C6, 32'h532201C6, 32'h455C01C6)};
        rst_n = 1'b0; in_valid = 1'b0; in_fwd = 1'b0; out_ready = 1'b0; in_state = '0;
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 128'(busy), 128'd0);

        for (int i = 0; i < 3; i++)
            do_block(vt[i].si, vt[i].fw, vt[i].se, got);

        // Backpressure: result held, second state refused while DONE
        exp_q.push_back(vt[0].se);
        in_state = vt[0].si; in_fwd = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_state = vt[1].si; in_fwd = 1'b1;
        wait_valid(n);
        chk("bp_latency", 128'(n), 128'd4);
        s = exp_q.pop_front();
        chk("bp_out_state", out_state, s);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_state", out_state, s);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_busy", 128'(busy), 128'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready), 128'd1);
        do_block(vt[1].si, 1'b1, vt[1].se, got);

        // Reset while col == 2 in CALC
        in_state = vt[0].si; in_fwd = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_out_state", out_state, 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        do_block(vt[0].si, 1'b0, vt[0].se, got);

        // Random round trips
        for (int i = 0; i < 200; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            do_block(s, 1'b1, model(s, 1'b1), got);
            do_block(got, 1'b0, s, back);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
